// File: rtl/display_write_port.sv
// Display write port: takes byte writes from an asynchronous CPU bus, queues
// them in a small FIFO for the downstream LED counter, and returns a status
// byte on the shared data bus during a CPU status read.
module display_write_port #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              enable,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake on the downstream side: an entry moves when out_valid and
    // out_ready are both 1 in the same cycle; out_valid never depends on
    // out_ready, and out_data is stable while out_valid is held.

    // Synchronizers and edge-detect history
    logic write_s1, write_s2, write_prev;
    logic enable_s1, enable_s2;
    logic read_s1, read_s2, read_prev;

    // live2 goes high once the synchronizer outputs reflect real inputs after
    // reset; write_armed then requires a synced-low write before any event,
    // so a strobe still high at reset release cannot create a push.
    logic live1, live2, write_armed;

    // FIFO state
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              ovf;
    logic [DATA_W-1:0] last_data;

    // Decoded controls
    logic              write_event;
    logic              full;
    logic              pop;
    logic              drop;
    logic              push;
    logic              ovf_clear;
    logic [3:0]        count_lo;
    logic [DATA_W-1:0] status;
    logic              bus_drive;

    // Two-flop synchronizers plus history flops for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_s1    <= 1'b0;
            write_s2    <= 1'b0;
            write_prev  <= 1'b0;
            enable_s1   <= 1'b0;
            enable_s2   <= 1'b0;
            read_s1     <= 1'b0;
            read_s2     <= 1'b0;
            read_prev   <= 1'b0;
            live1       <= 1'b0;
            live2       <= 1'b0;
            write_armed <= 1'b0;
        end else begin
            write_s1    <= write;
            write_s2    <= write_s1;
            write_prev  <= write_s2;
            enable_s1   <= enable;
            enable_s2   <= enable_s1;
            read_s1     <= read;
            read_s2     <= read_s1;
            read_prev   <= read_s2;
            live1       <= 1'b1;
            live2       <= live1;
            write_armed <= write_armed | (live2 & ~write_s2);
        end
    end

    // Event decode, FIFO flags and the status byte
    always_comb begin
        write_event = write_s2 & ~write_prev & enable_s2 & write_armed;
        full        = (count == CW'(DEPTH));
        out_valid   = (count != '0);
        pop         = out_valid & out_ready;
        drop        = write_event & full & ~pop;
        push        = write_event & ~drop;
        ovf_clear   = read_prev & ~read_s2 & enable_s2;
        // For DEPTH=16 the full count wraps to 0 in the 4-bit field.
        count_lo    = 4'(count);
        status      = {ovf, 2'b00, full, count_lo};
        // Raw strobes gate the driver so the byte appears within the CPU
        // access; a concurrent write always keeps the bus released.
        bus_drive   = enable & read & ~write;
        out_data    = out_valid ? mem[rd_ptr] : last_data;
    end

    assign data_bus = bus_drive ? status : {DATA_W{1'bz}};

    // Pointers, fill count, sticky overflow and last popped value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            last_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push in the same cycle as a clear keeps ovf set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clear) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; not reset, unread entries are masked by last_data
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_bus;
        end
    end

endmodule

// File: doc/display_write_port.md
DISPLAY_WRITE_PORT -- requirements
Module: display_write_port

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 Parameter DATA_W, default 8, data width; fixed at 8 for the CPU bus.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low, synchronous deassert by the system.
REQ-005 data_bus  inout  8  CPU data bus; sampled on write, driven only during a status read.
REQ-006 enable  input  1  chip select from the CPU address decoder; asynchronous to clk.
REQ-007 write  input  1  CPU write strobe, level-high; asynchronous to clk; data_bus stable while high.
REQ-008 read  input  1  CPU read strobe, level-high; asynchronous to clk.
REQ-009 out_data  output  8  head FIFO entry, feeding the downstream LED counter data input.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-012 The block SHALL pass write, enable and read each through a 2-flop synchronizer, plus one history flop for edge detection.
REQ-013 A write event SHALL be one clk cycle in which synced write is 1, previous synced write is 0, and synced enable is 1.
REQ-014 On a write event, the block SHALL capture data_bus in that cycle and push it into the FIFO.
REQ-015 Latency: CPU write rise to out_valid=1 (FIFO empty before) SHALL be 3 clk rising edges.
REQ-016 A held write level SHALL produce exactly one event; the next event requires write low for at least 1 synced cycle.
REQ-017 FIFO: DEPTH entries, log2(DEPTH)-bit read and write pointers with natural wrap, count of width log2(DEPTH)+1.
REQ-018 A pop SHALL occur when out_valid and out_ready are both 1; out_data SHALL present the next entry in the following cycle.
REQ-019 out_data SHALL be the head entry whenever out_valid=1 and SHALL hold its last value when empty.
REQ-020 Push while full without a simultaneous pop SHALL be dropped, leaving FIFO contents unchanged, and SHALL set the sticky ovf flag.
REQ-021 Push and pop in the same cycle SHALL both take effect at any fill level, including full, with count unchanged.
REQ-022 Pop while empty SHALL be impossible because out_valid=0; out_ready is ignored.
REQ-023 Status byte = {ovf, 2'b00, full, count[3:0]}; for DEPTH<16 count is zero-extended; for DEPTH=16, count[3:0] reads 0 when full and full=1.
REQ-024 data_bus SHALL be driven with the status byte combinationally while raw enable and read are both 1, and SHALL be high-Z otherwise.
REQ-025 data_bus SHALL never be driven while write=1; write takes priority over read.
REQ-026 ovf SHALL clear on the falling edge of synced read while synced enable is 1, so the read in progress still returns ovf=1.
REQ-027 A write event and ovf-clear in the same cycle, with the push overflowing, SHALL leave ovf=1 (set wins).

Reset
REQ-028 While rst_n=0, all synchronizer and history flops, both pointers, count and ovf SHALL be 0; out_valid=0; out_data=8'h00.
REQ-029 FIFO storage need not be cleared; out_data SHALL read 8'h00 until the first push.
REQ-030 Reset asserted mid-write SHALL discard the pending event; a write still high at release SHALL NOT create an event until write goes low then high again.
REQ-031 Reset during a status read SHALL keep data_bus driven with the post-reset status 8'h00.

Verification
REQ-032 Reset, then write 8'hA5 with enable=1, out_ready=0 -> out_valid=1 on the 3rd clk edge, out_data=8'hA5, status read returns 8'h01.
REQ-033 out_ready=0; write 8'h11, 8'h22, 8'h33, 8'h44, then 8'h55 -> status 8'h94 (ovf, full, count 4); drain yields 11,22,33,44 in order; a subsequent status read returns 8'h80 and, after read falls, 8'h00.
REQ-034 FIFO full, out_ready=1 held, write 8'h66 timed so push and pop coincide -> count stays 4, no ovf, 8'h66 emerges last.
REQ-035 write held high for 50 cycles with enable=1 -> exactly one push; enable=0 during write -> no push.
REQ-036 Assert rst_n=0 between the write rise and its detection -> FIFO empty, no push after release while write is still high.
